// File: rtl/dspi_arbiter_if.sv
// Requester/engine bundle around the shared display_spi byte engine.
// The arbiter takes the slave view; requesters and the engine take the master view.
interface dspi_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_cmd;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 dspi_ready;
  logic [2:0]           dspi_cmd;
  logic [7:0]           dspi_byte;
  logic                 lock_valid;
  logic [IDX_W-1:0]     lock_owner;
  logic                 err_timeout;

  modport master (
    output req_valid, req_cmd, req_byte, req_lock, dspi_ready,
    input  req_ready, dspi_cmd, dspi_byte, lock_valid, lock_owner, err_timeout
  );

  modport slave (
    input  req_valid, req_cmd, req_byte, req_lock, dspi_ready,
    output req_ready, dspi_cmd, dspi_byte, lock_valid, lock_owner, err_timeout
  );
endinterface

// File: rtl/dspi_arbiter.sv
// Round-robin arbiter sharing one display_spi byte engine between NUM_REQ requesters,
// with per-requester burst locking and a sticky timeout flag for a stuck engine.
module dspi_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           reset,
  dspi_arbiter_if.slave  bus
);
  localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int         TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [2:0] CMD_NONE = 3'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   lock_owner;
  logic               lock_valid;
  logic [2:0]         dspi_cmd;
  logic [7:0]         dspi_byte;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               err_timeout;

  logic               cand_found;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [2:0]         cand_cmd;
  logic [7:0]         cand_byte;
  logic               cand_lock;
  logic               accept;
  logic [NUM_REQ-1:0] req_ready;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    wrap_inc = (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  // A held lock pins the candidate to its owner; otherwise scan upward from rr_ptr.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = rr_ptr;
    scan_idx   = rr_ptr;
    if (lock_valid) begin
      cand_found = bus.req_valid[lock_owner];
      cand_idx   = lock_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!cand_found && bus.req_valid[scan_idx]) begin
          cand_found = 1'b1;
          cand_idx   = scan_idx;
        end
      end
    end
  end

  assign cand_cmd  = bus.req_cmd[cand_idx*3 +: 3];
  assign cand_byte = bus.req_byte[cand_idx*8 +: 8];
  assign cand_lock = bus.req_lock[cand_idx];
  assign accept    = (state == IDLE) && cand_found && bus.dspi_ready;

  always_comb begin
    req_ready           = '0;
    req_ready[cand_idx] = accept;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      dspi_cmd    <= CMD_NONE;
      dspi_byte   <= 8'd0;
      lock_valid  <= 1'b0;
      lock_owner  <= '0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr     <= wrap_inc(cand_idx);
            lock_valid <= cand_lock;
            if (cand_lock)
              lock_owner <= cand_idx;
            // NONE is consumed but never reaches the engine.
            if (cand_cmd != CMD_NONE) begin
              dspi_cmd  <= cand_cmd;
              dspi_byte <= cand_byte;
              state     <= ISSUE;
            end
          end else if (lock_valid && !bus.req_lock[lock_owner] && !bus.req_valid[lock_owner]) begin
            lock_valid <= 1'b0;
          end
        end
        ISSUE: begin
          dspi_cmd <= CMD_NONE;
          tmo_cnt  <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.dspi_ready) begin
            state <= IDLE;
          end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_cnt == TMO_W'(TIMEOUT - 1))
              err_timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.dspi_cmd    = dspi_cmd;
  assign bus.dspi_byte   = dspi_byte;
  assign bus.lock_valid  = lock_valid;
  assign bus.lock_owner  = lock_owner;
  assign bus.err_timeout = err_timeout;
endmodule

// File: tb/tb_dspi_arbiter.sv
// Randomized bench for dspi_arbiter: per-requester transaction queues, a simple engine
// model and a transaction-level reference for grant order, locking and issue timing.
module tb_dspi_arbiter;
  localparam int NUM_REQ = 3;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dspi_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  dspi_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] b;
    logic       lk;
  } txn_t;

  txn_t       q [NUM_REQ][$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_acc = 0;
  int         m_rr = 0;
  logic       m_lock = 1'b0;
  int         m_owner = 0;
  logic       exp_issue = 1'b0;
  logic [2:0] exp_cmd = 3'd0;
  logic [7:0] exp_byte = 8'd0;
  logic [7:0] last_byte = 8'd0;
  int         busy = 0;
  int         stall_len = 0;
  int         since_issue = 100;
  logic       pushing = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, req, $time);
    end
  endtask

  task automatic push_one(input int i, input logic [2:0] cmd, input logic [7:0] b, input logic lk);
    txn_t t;
    t.cmd = cmd; t.b = b; t.lk = lk;
    q[i].push_back(t);
  endtask

  // Bursts are queued whole, so a lock owner never runs dry mid-burst.
  task automatic push_burst(input int i, input int len);
    logic [2:0] c;
    for (int k = 0; k < len; k++) begin
      c = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
      push_one(i, c, 8'($urandom), k < len - 1);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_cmd[3*i +: 3]  = q[i][0].cmd;
        bus.req_byte[8*i +: 8] = q[i][0].b;
        bus.req_lock[i]        = q[i][0].lk;
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_cmd[3*i +: 3]  = 3'd0;
        bus.req_byte[8*i +: 8] = 8'($urandom);
        bus.req_lock[i]        = 1'b0;
      end
    end
  endtask

  function automatic int model_pick();
    int idx;
    if (m_lock) return m_owner;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_rr + k) % NUM_REQ;
      if (q[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += q[i].size();
    return n;
  endfunction

  task automatic step();
    logic was_issue;
    int   pick;
    txn_t t;
    @(negedge clk);
    if (exp_issue) begin
      check_val("issue_cmd", 32'(bus.dspi_cmd), 32'(exp_cmd));
      check_val("issue_byte", 32'(bus.dspi_byte), 32'(exp_byte));
      last_byte   = exp_byte;
      since_issue = 0;
    end else begin
      check_val("idle_cmd", 32'(bus.dspi_cmd), 32'd0);
      check_val("byte_hold", 32'(bus.dspi_byte), 32'(last_byte));
      since_issue++;
    end
    check_val("lock_valid", 32'(bus.lock_valid), 32'(m_lock));
    if (m_lock) check_val("lock_owner", 32'(bus.lock_owner), 32'(m_owner));
    // engine: busy for a while after each issued command
    if (bus.dspi_cmd != 3'd0) begin
      busy = (stall_len > 0) ? stall_len : $urandom_range(0, 6);
      stall_len = 0;
      bus.dspi_ready = 1'b0;
    end else if (busy > 0) begin
      busy--;
      bus.dspi_ready = (busy == 0);
    end else begin
      bus.dspi_ready = 1'b1;
    end
    was_issue = exp_issue;
    exp_issue = 1'b0;
    if (pushing)
      for (int i = 0; i < NUM_REQ; i++)
        if (q[i].size() < 3 && $urandom_range(0, 5) == 0) push_burst(i, $urandom_range(1, 3));
    drive_reqs();
    #1;
    if (bus.req_ready != '0) begin
      pick = model_pick();
      check_val("grant", 32'(bus.req_ready), (pick >= 0) ? (32'd1 << pick) : 32'd0);
      check_val("grant_ready", 32'(bus.dspi_ready), 32'd1);
      check_val("grant_in_issue", 32'(was_issue), 32'd0);
      if (pick >= 0) begin
        t = q[pick].pop_front();
        n_acc++;
        m_rr   = (pick + 1) % NUM_REQ;
        m_lock = t.lk;
        if (t.lk) m_owner = pick;
        if (t.cmd != 3'd0) begin
          exp_issue = 1'b1;
          exp_cmd   = t.cmd;
          exp_byte  = t.b;
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 3000 && (pending() > 0 || exp_issue || busy > 0); k++) step();
    check_val(tag, 32'(pending()), 32'd0);
  endtask

  task automatic wait_issue(input string tag);
    logic got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (since_issue == 0) begin got = 1'b1; break; end
    end
    check_val(tag, 32'(got), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.dspi_ready = 1'b1;
    drive_reqs();
    repeat (3) @(negedge clk);
    check_val("rst_cmd", 32'(bus.dspi_cmd), 32'd0);
    check_val("rst_byte", 32'(bus.dspi_byte), 32'd0);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_val("rst_lock_valid", 32'(bus.lock_valid), 32'd0);
    check_val("rst_lock_owner", 32'(bus.lock_owner), 32'd0);
    check_val("rst_err", 32'(bus.err_timeout), 32'd0);
    reset = 1'b1;

    // single requester, command byte 0xAE
    push_one(0, 3'd2, 8'hAE, 1'b0);
    step();
    check_val("single_accept", 32'(n_acc), 32'd1);
    drain("single_drain");

    // fixed lock burst from req1 while req0 is busy too
    push_one(0, 3'd3, 8'h01, 1'b0);
    push_one(0, 3'd3, 8'h02, 1'b0);
    push_one(1, 3'd2, 8'h21, 1'b1);
    push_one(1, 3'd3, 8'h00, 1'b1);
    push_one(1, 3'd3, 8'h7F, 1'b0);
    push_one(2, 3'd0, 8'h33, 1'b0);
    drain("lock_drain");

    // random traffic
    pushing = 1'b1;
    repeat (1500) step();
    pushing = 1'b0;
    drain("rand_drain");
    check_val("no_timeout", 32'(bus.err_timeout), 32'd0);

    // stuck engine
    stall_len = 30;
    push_one(0, 3'd3, 8'h55, 1'b0);
    wait_issue("tmo_issue_seen");
    repeat (TIMEOUT) step();
    check_val("tmo_before", 32'(bus.err_timeout), 32'd0);
    step();
    check_val("tmo_at", 32'(bus.err_timeout), 32'd1);
    drain("tmo_drain");
    push_one(1, 3'd2, 8'h66, 1'b0);
    drain("tmo_drain2");
    check_val("tmo_sticky", 32'(bus.err_timeout), 32'd1);

    // reset while waiting on the engine with a lock held
    stall_len = 15;
    push_one(1, 3'd2, 8'h21, 1'b1);
    push_one(1, 3'd3, 8'h00, 1'b1);
    push_one(1, 3'd3, 8'h7F, 1'b0);
    wait_issue("mid_issue_seen");
    step();
    step();
    check_val("mid_lock_held", 32'(bus.lock_valid), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus.dspi_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_val("mid_rst_lock", 32'(bus.lock_valid), 32'd0);
    check_val("mid_rst_cmd", 32'(bus.dspi_cmd), 32'd0);
    check_val("mid_rst_byte", 32'(bus.dspi_byte), 32'd0);
    check_val("mid_rst_err", 32'(bus.err_timeout), 32'd0);
    m_rr = 0; m_lock = 1'b0; m_owner = 0;
    exp_issue = 1'b0; last_byte = 8'd0; stall_len = 0;
    push_one(0, 3'd3, 8'hA0, 1'b0);
    push_one(2, 3'd3, 8'hC0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_reqs();
      #1;
      check_val("no_accept_busy", 32'(bus.req_ready), 32'd0);
    end
    busy = 0;
    drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
